// File: rtl/uart_tx_engine_if.sv
// FIFO read port between the TX-path FIFO and the UART transmit engine.
// The engine is the master: it watches empty/head data and issues the pop strobe.
interface uart_tx_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_r_data;
    logic                  fifo_rd;

    modport master (input fifo_empty, input fifo_r_data, output fifo_rd);
    modport slave  (output fifo_empty, output fifo_r_data, input fifo_rd);
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops one word from the TX FIFO when idle and serialises it
// as start bit, DATA_WIDTH data bits LSB first and an SB_TICK-long stop period.
module uart_tx_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICK    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_tick,
    uart_tx_engine_if.master fifo,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done_tick
);
    localparam int            NW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [4:0]    BIT_LAST  = 5'd15;
    localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [4:0]            s_cnt_q, s_cnt_d;
    logic [NW-1:0]         n_cnt_q, n_cnt_d;
    logic [DATA_WIDTH-1:0] b_reg_q, b_reg_d;
    logic                  tx_q, tx_d;
    logic                  rd;
    logic                  done;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_reg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_reg_q <= b_reg_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_reg_d = b_reg_q;
        rd      = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                // A tick coinciding with the pop is deliberately not counted.
                if (!fifo.fifo_empty && !reset) begin
                    rd      = 1'b1;
                    b_reg_d = fifo.fifo_r_data;
                    s_cnt_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        state_d = DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        b_reg_d = b_reg_q >> 1;
                        if (n_cnt_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == STOP_LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is registered, so it follows the state being entered.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_reg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign fifo.fifo_rd  = rd;
    assign tx            = tx_q;
    assign tx_busy       = (state_q != IDLE);
    assign tx_done_tick  = done;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: FIFO and receiver models, one task per scenario.
// Two instances share clk/reset/s_tick: SB_TICK = 16 and SB_TICK = 32.
module tb_uart_tx_engine;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    logic s_tick;
    logic tx16, busy16, done16;
    logic tx32, busy32, done32;

    int n_checks = 0;
    int n_pass   = 0;
    int tick_mode = 0;

    uart_tx_engine_if #(.DATA_WIDTH(DW)) f16 ();
    uart_tx_engine_if #(.DATA_WIDTH(DW)) f32 ();

    uart_tx_engine #(.DATA_WIDTH(DW), .SB_TICK(16)) dut16 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .fifo(f16.master),
        .tx(tx16), .tx_busy(busy16), .tx_done_tick(done16)
    );

    uart_tx_engine #(.DATA_WIDTH(DW), .SB_TICK(32)) dut32 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .fifo(f32.master),
        .tx(tx32), .tx_busy(busy32), .tx_done_tick(done32)
    );

    always #5 clk = ~clk;

    // Baud tick: every 4 clk, or a random 1..7 clk spacing when tick_mode is set.
    initial begin
        int cnt;
        int gap;
        s_tick = 1'b0;
        cnt = 0;
        gap = 4;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt >= gap) begin
                s_tick = 1'b1;
                cnt = 0;
                gap = (tick_mode != 0) ? int'($urandom_range(7, 1)) : 4;
            end else begin
                s_tick = 1'b0;
            end
        end
    end

    // FIFO models: head/empty refreshed on the falling edge, pops taken on the rising edge.
    logic [DW-1:0] q16[$];
    logic [DW-1:0] q32[$];
    int pop16 = 0, pop32 = 0, rd_empty16 = 0, rd_empty32 = 0;

    initial begin
        f16.fifo_empty = 1'b1;
        f16.fifo_r_data = '0;
        f32.fifo_empty = 1'b1;
        f32.fifo_r_data = '0;
        forever begin
            @(negedge clk);
            f16.fifo_empty  = (q16.size() == 0);
            f16.fifo_r_data = (q16.size() != 0) ? q16[0] : '0;
            f32.fifo_empty  = (q32.size() == 0);
            f32.fifo_r_data = (q32.size() != 0) ? q32[0] : '0;
        end
    end

    always @(posedge clk) begin
        if (f16.fifo_rd === 1'b1) begin
            pop16++;
            if (f16.fifo_empty !== 1'b0 || q16.size() == 0) rd_empty16++;
            else void'(q16.pop_front());
        end
        if (f32.fifo_rd === 1'b1) begin
            pop32++;
            if (f32.fifo_empty !== 1'b0 || q32.size() == 0) rd_empty32++;
            else void'(q32.pop_front());
        end
    end

    // Receiver model for the SB_TICK=16 instance: samples mid-bit by counting s_ticks.
    logic [DW-1:0] rx16[$];
    int            rx_err16 = 0;
    bit            rx_act = 1'b0;
    bit            rx_bad;
    int            rx_cnt;
    logic [DW-1:0] rx_sh;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx16 === 1'b0) begin
                rx_act = 1'b1;
                rx_bad = 1'b0;
                rx_cnt = (s_tick === 1'b1) ? 1 : 0;
            end
        end else if (s_tick === 1'b1) begin
            rx_cnt++;
            if (rx_cnt == 8) begin
                if (tx16 !== 1'b0) rx_bad = 1'b1;
            end else if (rx_cnt >= 24 && rx_cnt <= 24 + 16 * (DW - 1) && (rx_cnt - 24) % 16 == 0) begin
                rx_sh = {tx16, rx_sh[DW-1:1]};
            end else if (rx_cnt == 24 + 16 * DW) begin
                if (tx16 !== 1'b1) rx_bad = 1'b1;
                rx16.push_back(rx_sh);
                if (rx_bad) rx_err16++;
                rx_act = 1'b0;
            end
        end
    end

    // which: 0 = tx16, 1 = tx32, 2 = done16, 3 = done32. Returns on the matching falling edge.
    task automatic wait_sig(input int which, input logic level, input int limit, output bit ok);
        logic v;
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            case (which)
                0:       v = tx16;
                1:       v = tx32;
                2:       v = done16;
                default: v = done32;
            endcase
            if (v === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Push on a clk cycle that carries s_tick, so START lasts a full 16 x 4 clk.
    task automatic push_aligned(input bit sel32, input logic [DW-1:0] b);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (s_tick !== 1'b1 && n < 64);
        if (sel32) q32.push_back(b);
        else q16.push_back(b);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (tx16 !== 1'b1)       $display("FAIL reset_tx16: got %b want 1", tx16); else n_pass++;
        n_checks++; if (busy16 !== 1'b0)     $display("FAIL reset_busy16: got %b want 0", busy16); else n_pass++;
        n_checks++; if (done16 !== 1'b0)     $display("FAIL reset_done16: got %b want 0", done16); else n_pass++;
        n_checks++; if (f16.fifo_rd !== 1'b0) $display("FAIL reset_rd16: got %b want 0", f16.fifo_rd); else n_pass++;
        n_checks++; if (tx32 !== 1'b1)       $display("FAIL reset_tx32: got %b want 1", tx32); else n_pass++;
        n_checks++; if (busy32 !== 1'b0)     $display("FAIL reset_busy32: got %b want 0", busy32); else n_pass++;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_single_byte();
        logic [9:0] pat;
        int lvl_cnt[10];
        int busy_cnt, done_cnt, done_at, base_pop, base_err;
        bit ok;
        pat = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10; i++) lvl_cnt[i] = 0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        tick_mode = 0;
        rx16.delete();
        base_pop = pop16;
        base_err = rx_err16;
        push_aligned(1'b0, 8'h55);
        wait_sig(0, 1'b0, 200, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL single_start: tx fell %b want 1", ok); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 640; i++) begin
                if (i > 0) @(negedge clk);
                if (tx16 === pat[i / 64]) lvl_cnt[i / 64]++;
                if (busy16 === 1'b1) busy_cnt++;
                if (done16 === 1'b1) begin
                    done_cnt++;
                    if (done_at < 0) done_at = i;
                end
            end
            for (int b = 0; b < 10; b++) begin
                n_checks++;
                if (lvl_cnt[b] != 64) $display("FAIL single_bit%0d: got %0d clk at level %b want 64", b, lvl_cnt[b], pat[b]);
                else n_pass++;
            end
            n_checks++; if (busy_cnt != 640) $display("FAIL single_busy_len: got %0d want 640", busy_cnt); else n_pass++;
            n_checks++; if (done_cnt != 1 || done_at != 639)
                $display("FAIL single_done: got %0d pulses first at %0d want 1 at 639", done_cnt, done_at); else n_pass++;
            @(negedge clk);
            n_checks++; if (busy16 !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy16); else n_pass++;
            n_checks++; if (tx16 !== 1'b1)   $display("FAIL single_tx_after: got %b want 1", tx16); else n_pass++;
        end
        n_checks++; if (pop16 - base_pop != 1) $display("FAIL single_pops: got %0d want 1", pop16 - base_pop); else n_pass++;
        n_checks++; if (rx16.size() != 1 || rx16[0] !== 8'h55)
            $display("FAIL single_rx: got %0d bytes first %h want 1 byte 55", rx16.size(), (rx16.size() != 0) ? rx16[0] : 8'hxx); else n_pass++;
        n_checks++; if (rx_err16 != base_err) $display("FAIL single_framing: got %0d errors want 0", rx_err16 - base_err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_b[3];
        int base_pop, base_err, idle_n, idle_bad;
        bit ok;
        exp_b[0] = 8'hA3; exp_b[1] = 8'h0F; exp_b[2] = 8'hFF;
        tick_mode = 0;
        rx16.delete();
        base_pop = pop16;
        base_err = rx_err16;
        push_aligned(1'b0, exp_b[0]);
        q16.push_back(exp_b[1]);
        q16.push_back(exp_b[2]);
        for (int f = 0; f < 3; f++) begin
            wait_sig(2, 1'b1, 1000, ok);
            n_checks++; if (ok !== 1'b1) $display("FAIL b2b_done%0d: seen %b want 1", f, ok); else n_pass++;
            if (f < 2) begin
                idle_n = 0;
                idle_bad = 0;
                @(negedge clk);
                while (busy16 === 1'b0 && idle_n < 10) begin
                    idle_n++;
                    if (tx16 !== 1'b1) idle_bad++;
                    @(negedge clk);
                end
                n_checks++; if (idle_n != 1 || idle_bad != 0)
                    $display("FAIL b2b_gap%0d: got %0d idle clk (%0d low) want 1 high", f, idle_n, idle_bad); else n_pass++;
            end
        end
        n_checks++; if (rx16.size() != 3) $display("FAIL b2b_count: got %0d frames want 3", rx16.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= rx16.size())          $display("FAIL b2b_byte%0d: missing want %h", i, exp_b[i]);
            else if (rx16[i] !== exp_b[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, rx16[i], exp_b[i]);
            else n_pass++;
        end
        n_checks++; if (pop16 - base_pop != 3) $display("FAIL b2b_pops: got %0d want 3", pop16 - base_pop); else n_pass++;
        n_checks++; if (rx_err16 != base_err) $display("FAIL b2b_framing: got %0d errors want 0", rx_err16 - base_err); else n_pass++;
    endtask

    task automatic test_stop_length();
        int low_clk, stop_clk, stop_ticks, stop_bad, base_pop;
        bit ok, seen;
        tick_mode = 0;
        base_pop = pop32;
        push_aligned(1'b1, 8'h00);
        wait_sig(1, 1'b0, 200, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL stop_start: tx fell %b want 1", ok); else n_pass++;
        low_clk = 0;
        while (tx32 === 1'b0 && low_clk < 1000) begin
            low_clk++;
            @(negedge clk);
        end
        n_checks++; if (low_clk != 576) $display("FAIL stop_low_len: got %0d clk want 576", low_clk); else n_pass++;
        stop_clk = 0; stop_ticks = 0; stop_bad = 0; seen = 1'b0;
        while (stop_clk < 1000) begin
            stop_clk++;
            if (s_tick === 1'b1) stop_ticks++;
            if (tx32 !== 1'b1) stop_bad++;
            if (done32 === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b1)   $display("FAIL stop_done_seen: got %b want 1", seen); else n_pass++;
        n_checks++; if (stop_ticks != 32) $display("FAIL stop_ticks: got %0d want 32", stop_ticks); else n_pass++;
        n_checks++; if (stop_clk != 128)  $display("FAIL stop_clk: got %0d want 128", stop_clk); else n_pass++;
        n_checks++; if (stop_bad != 0)    $display("FAIL stop_level: got %0d low clk want 0", stop_bad); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy32 !== 1'b0) $display("FAIL stop_busy_after: got %b want 0", busy32); else n_pass++;
        n_checks++; if (pop32 - base_pop != 1) $display("FAIL stop_pops: got %0d want 1", pop32 - base_pop); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int base_pop, base_err;
        bit ok;
        tick_mode = 0;
        rx16.delete();
        push_aligned(1'b0, 8'h81);
        wait_sig(0, 1'b0, 200, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL rst_start: tx fell %b want 1", ok); else n_pass++;
        repeat (202) @(negedge clk);
        n_checks++; if (busy16 !== 1'b1) $display("FAIL rst_in_frame: got busy %b want 1", busy16); else n_pass++;
        base_pop = pop16;
        base_err = rx_err16;
        @(posedge clk);
        #2;
        reset = 1'b1;
        q16.push_back(8'h7E);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (tx16 !== 1'b1)       $display("FAIL rst_tx: got %b want 1", tx16); else n_pass++;
        n_checks++; if (busy16 !== 1'b0)     $display("FAIL rst_busy: got %b want 0", busy16); else n_pass++;
        n_checks++; if (f16.fifo_rd !== 1'b0) $display("FAIL rst_rd_held: got %b want 0", f16.fifo_rd); else n_pass++;
        @(posedge clk);
        #2;
        n_checks++; if (pop16 != base_pop) $display("FAIL rst_no_pop: got %0d pops want 0", pop16 - base_pop); else n_pass++;
        reset = 1'b0;
        wait_sig(2, 1'b1, 1000, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL rst_next_done: seen %b want 1", ok); else n_pass++;
        n_checks++; if (rx16.size() != 1 || rx16[0] !== 8'h7E)
            $display("FAIL rst_next_rx: got %0d bytes first %h want 1 byte 7e", rx16.size(), (rx16.size() != 0) ? rx16[0] : 8'hxx); else n_pass++;
        n_checks++; if (pop16 - base_pop != 1) $display("FAIL rst_next_pops: got %0d want 1", pop16 - base_pop); else n_pass++;
        n_checks++; if (rx_err16 != base_err) $display("FAIL rst_framing: got %0d errors want 0", rx_err16 - base_err); else n_pass++;
    endtask

    task automatic test_tick_gaps();
        logic [DW-1:0] exp_b[2];
        int base_pop, base_err, ticks, n;
        bit ok;
        exp_b[0] = 8'hC6; exp_b[1] = 8'h39;
        tick_mode = 1;
        rx16.delete();
        base_pop = pop16;
        base_err = rx_err16;
        @(posedge clk);
        #2;
        q16.push_back(exp_b[0]);
        q16.push_back(exp_b[1]);
        for (int f = 0; f < 2; f++) begin
            wait_sig(0, 1'b0, 100, ok);
            ticks = 0;
            n = 0;
            while (ok && n < 3000) begin
                n++;
                if (s_tick === 1'b1) ticks++;
                if (done16 === 1'b1) break;
                @(negedge clk);
            end
            n_checks++; if (ticks != 160) $display("FAIL gaps_frame%0d_ticks: got %0d want 160", f, ticks); else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= rx16.size())          $display("FAIL gaps_byte%0d: missing want %h", i, exp_b[i]);
            else if (rx16[i] !== exp_b[i]) $display("FAIL gaps_byte%0d: got %h want %h", i, rx16[i], exp_b[i]);
            else n_pass++;
        end
        n_checks++; if (pop16 - base_pop != 2) $display("FAIL gaps_pops: got %0d want 2", pop16 - base_pop); else n_pass++;
        n_checks++; if (rx_err16 != base_err) $display("FAIL gaps_framing: got %0d errors want 0", rx_err16 - base_err); else n_pass++;
        tick_mode = 0;
    endtask

    task automatic test_empty_idle();
        int bad_tx, bad_rd, bad_busy;
        bad_tx = 0; bad_rd = 0; bad_busy = 0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx16 !== 1'b1 || tx32 !== 1'b1) bad_tx++;
            if (f16.fifo_rd !== 1'b0 || f32.fifo_rd !== 1'b0) bad_rd++;
            if (busy16 !== 1'b0 || busy32 !== 1'b0) bad_busy++;
        end
        n_checks++; if (bad_tx != 0)   $display("FAIL idle_tx: got %0d bad clk want 0", bad_tx); else n_pass++;
        n_checks++; if (bad_rd != 0)   $display("FAIL idle_rd: got %0d bad clk want 0", bad_rd); else n_pass++;
        n_checks++; if (bad_busy != 0) $display("FAIL idle_busy: got %0d bad clk want 0", bad_busy); else n_pass++;
        n_checks++; if (rd_empty16 + rd_empty32 != 0)
            $display("FAIL rd_while_empty: got %0d pops on empty want 0", rd_empty16 + rd_empty32); else n_pass++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit at %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_stop_length();
        test_reset_mid_frame();
        test_tick_gaps();
        test_empty_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
